// File: rtl/hdmi_frame_gate.sv
// hdmi_frame_gate
//   Passes decoded HDMI pixels to the rx pixel FIFO only for whole, correctly
//   sized frames. Capture starts at the first line after a vsync rise, every
//   line is checked against HPIXELS and every frame against VLINES. Short or
//   long lines and FIFO overflow drop the rest of the frame and resync at the
//   next vsync.
//
// Ports
//   clk          receiver pixel clock (only clock)
//   rstbtn_n     asynchronous active-low reset
//   enable       level, permits frame capture
//   clr_err      pulse, clears line_err / overflow (a same-cycle set wins)
//   in_de/in_vsync/in_hsync, in_pixel[23:0]  decoder timing + {b,g,r}
//   fifo_full    downstream FIFO full flag
//   out_wr_en    FIFO write enable (registered, 1 cycle after the pixel)
//   out_data     {de, vsync, hsync, pixel} of the written pixel
//   started      high while streaming
//   frame_ok     1-cycle pulse per good frame
//   line_err, overflow  sticky error flags
//   frame_count  good frames, wraps at 255
module hdmi_frame_gate #(
  parameter logic [10:0] HPIXELS = 11'd640,
  parameter logic [10:0] VLINES  = 11'd480
) (
  input  logic        clk,
  input  logic        rstbtn_n,
  input  logic        enable,
  input  logic        clr_err,
  input  logic        in_de,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic [23:0] in_pixel,
  input  logic        fifo_full,
  output logic        out_wr_en,
  output logic [26:0] out_data,
  output logic        started,
  output logic        frame_ok,
  output logic        line_err,
  output logic        overflow,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {IDLE, SYNC, ARMED, STREAM} state_e;

  localparam logic [10:0] CNT_MAX = 11'h7FF;

  state_e      state_q, state_d;
  logic        de_q, vs_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        wr_d, ok_d, lerr_set, ovf_set;
  logic        wr_q, ok_q, lerr_q, ovf_q;
  logic [26:0] data_q;
  logic [7:0]  fcnt_q;

  logic vs_rise, de_rise, de_fall;
  assign vs_rise = in_vsync & ~vs_q;
  assign de_rise = in_de & ~de_q;
  assign de_fall = ~in_de & de_q;

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    wr_d     = 1'b0;
    ok_d     = 1'b0;
    lerr_set = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (enable) state_d = SYNC;
      end
      SYNC: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (!enable)     state_d = IDLE;
        else if (vs_rise) state_d = ARMED;
      end
      ARMED: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (!enable) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          // vsync beats a coinciding de edge; keep waiting for the first line
          state_d = ARMED;
        end else if (de_rise) begin
          // first pixel of the frame is treated exactly like a STREAM pixel
          if (fifo_full) begin
            ovf_set = 1'b1;
            state_d = SYNC;
          end else begin
            wr_d    = 1'b1;
            hcnt_d  = 11'd1;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (vs_rise) begin
          // frame close; enable is only sampled here so a frame is never cut
          if (vcnt_q == VLINES) ok_d = 1'b1;
          else                  lerr_set = 1'b1;
          hcnt_d  = '0;
          vcnt_d  = '0;
          state_d = enable ? ARMED : IDLE;
        end else if (in_de) begin
          if (fifo_full) begin
            ovf_set = 1'b1;
            hcnt_d  = '0;
            vcnt_d  = '0;
            state_d = SYNC;
          end else begin
            wr_d = 1'b1;
            if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 11'd1;
          end
        end else if (de_fall) begin
          hcnt_d = '0;
          if (hcnt_q != HPIXELS) begin
            lerr_set = 1'b1;
            vcnt_d   = '0;
            state_d  = SYNC;
          end else if (vcnt_q != CNT_MAX) begin
            vcnt_d = vcnt_q + 11'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state_q <= IDLE;
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      lerr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      de_q    <= in_de;
      vs_q    <= in_vsync;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      wr_q    <= wr_d;
      if (wr_d) data_q <= {in_de, in_vsync, in_hsync, in_pixel};
      ok_q    <= ok_d;
      // set has priority over a coinciding clear
      lerr_q  <= lerr_set | (lerr_q & ~clr_err);
      ovf_q   <= ovf_set | (ovf_q & ~clr_err);
      fcnt_q  <= fcnt_q + 8'(ok_d);
    end
  end

  assign out_wr_en   = wr_q;
  assign out_data    = data_q;
  assign started     = (state_q == STREAM);
  assign frame_ok    = ok_q;
  assign line_err    = lerr_q;
  assign overflow    = ovf_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_hdmi_frame_gate.sv
// Bench for hdmi_frame_gate on a reduced 8x4 raster. Each frame is generated
// with random blanking, pixel data and hsync; the bench predicts from the
// frame rules which pixels must appear at the FIFO port (and on which cycle),
// how many good-frame pulses occur and what the flags/count must read.
module tb_hdmi_frame_gate;
  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rstbtn_n, enable, clr_err;
  logic        in_de, in_vsync, in_hsync, fifo_full;
  logic [23:0] in_pixel;
  logic        out_wr_en, started, frame_ok, line_err, overflow;
  logic [26:0] out_data;
  logic [7:0]  frame_count;

  hdmi_frame_gate #(.HPIXELS(11'd8), .VLINES(11'd4)) dut (
    .clk(clk), .rstbtn_n(rstbtn_n), .enable(enable), .clr_err(clr_err),
    .in_de(in_de), .in_vsync(in_vsync), .in_hsync(in_hsync),
    .in_pixel(in_pixel), .fifo_full(fifo_full),
    .out_wr_en(out_wr_en), .out_data(out_data), .started(started),
    .frame_ok(frame_ok), .line_err(line_err), .overflow(overflow),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [26:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t act_q[$];
  wr_t mw;
  int  cyc = 0;
  int  ok_cnt = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  mdl_fc = 0;
  bit  cap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_wr_en === 1'b1) begin
      mw.c = cyc;
      mw.d = out_data;
      act_q.push_back(mw);
    end
    if (frame_ok === 1'b1) ok_cnt = ok_cnt + 1;
  end

  task automatic step(input logic de, input logic vs, input logic hs,
                      input logic [23:0] px, input logic ff);
    in_de = de; in_vsync = vs; in_hsync = hs; in_pixel = px; fifo_full = ff;
    @(posedge clk); #1;
  endtask

  task automatic drive_vsync(input logic de_on_rise);
    step(de_on_rise, 1'b1, 1'b0, 24'($urandom), 1'b0);
    step(1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
  endtask

  // One frame: vsync, V lines of random blanking + pixels, front porch.
  // Expected writes are queued while cap is set.
  task automatic drive_frame(input int short_line, input int ovf_line,
                             input int ovf_pix, input int en_drop_line,
                             input logic clr_on_ovf);
    int nb, np;
    logic [23:0] px;
    logic hs, ff;
    wr_t e;
    drive_vsync(1'b0);
    for (int l = 0; l < V; l++) begin
      if (l == en_drop_line) enable = 1'b0;
      nb = $urandom_range(2, 5);
      for (int b = 0; b < nb; b++) step(1'b0, 1'b0, (b < 2), 24'd0, 1'b0);
      np = (l == short_line) ? H - 1 : H;
      for (int p = 0; p < np; p++) begin
        px = 24'($urandom);
        hs = 1'($urandom);
        ff = (l == ovf_line && p == ovf_pix);
        if (ff) begin
          cap = 1'b0;
          clr_err = clr_on_ovf;
        end else if (cap) begin
          e.c = cyc + 1;
          e.d = {1'b1, 1'b0, hs, px};
          exp_q.push_back(e);
        end
        step(1'b1, 1'b0, hs, px, ff);
        clr_err = 1'b0;
      end
      if (l == short_line) cap = 1'b0;
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
  endtask

  task automatic clear_log();
    exp_q.delete();
    act_q.delete();
    ok_cnt = 0;
  endtask

  task automatic test_reset();
    clear_log();
    n_chk++;
    if ({out_wr_en, out_data, started, frame_ok, line_err, overflow, frame_count} !== '0)
      $display("FAIL reset_outputs: got wr=%b data=%h st=%b ok=%b le=%b ov=%b fc=%0d, want all 0",
               out_wr_en, out_data, started, frame_ok, line_err, overflow, frame_count);
    else n_pass++;
    rstbtn_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    cap = 1'b0;
    drive_frame(-1, -1, -1, -1, 1'b0);
    n_chk++;
    if (act_q.size() != 0) $display("FAIL disabled_writes: got %0d want 0", act_q.size());
    else n_pass++;
    n_chk++;
    if (started !== 1'b0) $display("FAIL disabled_started: got %b want 0", started);
    else n_pass++;
  endtask

  task automatic test_two_frames();
    int bad;
    clear_log();
    enable = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    cap = 1'b1; drive_frame(-1, -1, -1, -1, 1'b0);
    cap = 1'b1; drive_frame(-1, -1, -1, -1, 1'b0);
    drive_vsync(1'b0);
    mdl_fc += 2;
    n_chk++;
    if (act_q.size() != exp_q.size()) $display("FAIL two_frames_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    foreach (exp_q[i]) if (i < act_q.size() && (act_q[i].c != exp_q[i].c || act_q[i].d !== exp_q[i].d)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL two_frames_wr_data: got %0d bad writes want 0", bad); else n_pass++;
    n_chk++;
    if (ok_cnt != 2) $display("FAIL two_frames_ok: got %0d want 2", ok_cnt); else n_pass++;
    n_chk++;
    if (frame_count !== 8'(mdl_fc)) $display("FAIL two_frames_count: got %0d want %0d", frame_count, mdl_fc);
    else n_pass++;
    n_chk++;
    if ({line_err, overflow} !== 2'b00) $display("FAIL two_frames_err: got %b%b want 00", line_err, overflow);
    else n_pass++;
  endtask

  task automatic test_short_line();
    int bad, s;
    clear_log();
    s = $urandom_range(0, V - 1);
    cap = 1'b1; drive_frame(-1, -1, -1, -1, 1'b0);
    cap = 1'b1; drive_frame(s, -1, -1, -1, 1'b0);
    n_chk++;
    if ({line_err, started} !== 2'b10) $display("FAIL short_flag: got le=%b st=%b want le=1 st=0", line_err, started);
    else n_pass++;
    cap = 1'b1; drive_frame(-1, -1, -1, -1, 1'b0);
    drive_vsync(1'b0);
    mdl_fc += 2;
    n_chk++;
    if (act_q.size() != exp_q.size()) $display("FAIL short_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    foreach (exp_q[i]) if (i < act_q.size() && (act_q[i].c != exp_q[i].c || act_q[i].d !== exp_q[i].d)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL short_wr_data: got %0d bad writes want 0", bad); else n_pass++;
    n_chk++;
    if (ok_cnt != 2) $display("FAIL short_ok: got %0d want 2", ok_cnt); else n_pass++;
    n_chk++;
    if (frame_count !== 8'(mdl_fc)) $display("FAIL short_count: got %0d want %0d", frame_count, mdl_fc);
    else n_pass++;
    clr_err = 1'b1; step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    clr_err = 1'b0; step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    n_chk++;
    if (line_err !== 1'b0) $display("FAIL short_clear: got %b want 0", line_err); else n_pass++;
  endtask

  task automatic test_overflow();
    int bad, l, p;
    clear_log();
    l = $urandom_range(1, V - 1);
    p = $urandom_range(0, H - 1);
    // clr_err coincides with the overflow: the set must win
    cap = 1'b1; drive_frame(-1, l, p, -1, 1'b1);
    n_chk++;
    if ({overflow, started, line_err} !== 3'b100)
      $display("FAIL ovf_flag: got ov=%b st=%b le=%b want ov=1 st=0 le=0", overflow, started, line_err);
    else n_pass++;
    clr_err = 1'b1; step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    clr_err = 1'b0; step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    n_chk++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
    cap = 1'b1; drive_frame(-1, -1, -1, -1, 1'b0);
    drive_vsync(1'b0);
    mdl_fc += 1;
    n_chk++;
    if (act_q.size() != exp_q.size()) $display("FAIL ovf_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    foreach (exp_q[i]) if (i < act_q.size() && (act_q[i].c != exp_q[i].c || act_q[i].d !== exp_q[i].d)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL ovf_wr_data: got %0d bad writes want 0", bad); else n_pass++;
    n_chk++;
    if (ok_cnt != 1 || frame_count !== 8'(mdl_fc))
      $display("FAIL ovf_count: got ok=%0d fc=%0d want ok=1 fc=%0d", ok_cnt, frame_count, mdl_fc);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    int bad, d;
    clear_log();
    d = $urandom_range(1, V - 1);
    cap = 1'b1; drive_frame(-1, -1, -1, d, 1'b0);
    drive_vsync(1'b0);
    mdl_fc += 1;
    n_chk++;
    if (started !== 1'b0) $display("FAIL drop_idle: got started=%b want 0", started); else n_pass++;
    cap = 1'b0; drive_frame(-1, -1, -1, -1, 1'b0);
    drive_vsync(1'b0);
    n_chk++;
    if (act_q.size() != exp_q.size()) $display("FAIL drop_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    foreach (exp_q[i]) if (i < act_q.size() && (act_q[i].c != exp_q[i].c || act_q[i].d !== exp_q[i].d)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL drop_wr_data: got %0d bad writes want 0", bad); else n_pass++;
    n_chk++;
    if (ok_cnt != 1 || frame_count !== 8'(mdl_fc))
      $display("FAIL drop_count: got ok=%0d fc=%0d want ok=1 fc=%0d", ok_cnt, frame_count, mdl_fc);
    else n_pass++;
    enable = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    int bad;
    clear_log();
    n_chk++;
    if (frame_count !== 8'(mdl_fc)) $display("FAIL areset_pre_count: got %0d want %0d", frame_count, mdl_fc);
    else n_pass++;
    cap = 1'b1;
    fork
      drive_frame(-1, -1, -1, -1, 1'b0);
      begin
        repeat (22) @(posedge clk);
        #6;
        rstbtn_n = 1'b0;
        cap = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].c > cyc) void'(exp_q.pop_back());
        #1;
        n_chk++;
        if ({out_wr_en, out_data, started, frame_ok, line_err, overflow, frame_count} !== '0)
          $display("FAIL areset_outputs: got wr=%b data=%h st=%b ok=%b le=%b ov=%b fc=%0d, want all 0",
                   out_wr_en, out_data, started, frame_ok, line_err, overflow, frame_count);
        else n_pass++;
        #1;
        rstbtn_n = 1'b1;
        mdl_fc = 0;
      end
    join
    cap = 1'b1; drive_frame(-1, -1, -1, -1, 1'b0);
    drive_vsync(1'b0);
    mdl_fc += 1;
    n_chk++;
    if (act_q.size() != exp_q.size()) $display("FAIL areset_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    foreach (exp_q[i]) if (i < act_q.size() && (act_q[i].c != exp_q[i].c || act_q[i].d !== exp_q[i].d)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL areset_wr_data: got %0d bad writes want 0", bad); else n_pass++;
    n_chk++;
    if (ok_cnt != 1 || frame_count !== 8'(mdl_fc))
      $display("FAIL areset_count: got ok=%0d fc=%0d want ok=1 fc=%0d", ok_cnt, frame_count, mdl_fc);
    else n_pass++;
  endtask

  task automatic test_vs_de_collision();
    int bad;
    clear_log();
    cap = 1'b1; drive_frame(-1, -1, -1, -1, 1'b0);
    drive_vsync(1'b1);
    cap = 1'b1; drive_frame(-1, -1, -1, -1, 1'b0);
    drive_vsync(1'b0);
    mdl_fc += 2;
    n_chk++;
    if (act_q.size() != exp_q.size()) $display("FAIL collide_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    foreach (exp_q[i]) if (i < act_q.size() && (act_q[i].c != exp_q[i].c || act_q[i].d !== exp_q[i].d)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL collide_wr_data: got %0d bad writes want 0", bad); else n_pass++;
    n_chk++;
    if (ok_cnt != 2 || frame_count !== 8'(mdl_fc) || line_err !== 1'b0)
      $display("FAIL collide_count: got ok=%0d fc=%0d le=%b want ok=2 fc=%0d le=0", ok_cnt, frame_count, line_err, mdl_fc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int bad;
    clear_log();
    rstbtn_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    rstbtn_n = 1'b1;
    mdl_fc = 0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    for (int f = 0; f < 256; f++) begin
      cap = 1'b1;
      drive_frame(-1, -1, -1, -1, 1'b0);
    end
    n_chk++;
    if (frame_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", frame_count); else n_pass++;
    drive_vsync(1'b0);
    n_chk++;
    if (frame_count !== 8'd0) $display("FAIL wrap_0: got %0d want 0", frame_count); else n_pass++;
    n_chk++;
    if (ok_cnt != 256) $display("FAIL wrap_ok: got %0d want 256", ok_cnt); else n_pass++;
    n_chk++;
    if (act_q.size() != exp_q.size()) $display("FAIL wrap_wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    foreach (exp_q[i]) if (i < act_q.size() && (act_q[i].c != exp_q[i].c || act_q[i].d !== exp_q[i].d)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL wrap_wr_data: got %0d bad writes want 0", bad); else n_pass++;
  endtask

  initial begin
    rstbtn_n = 1'b0; enable = 1'b0; clr_err = 1'b0;
    in_de = 1'b0; in_vsync = 1'b0; in_hsync = 1'b0; in_pixel = 24'd0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_two_frames();
    test_short_line();
    test_overflow();
    test_enable_drop();
    test_async_reset();
    test_vs_de_collision();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
